// File: rtl/vending_machine_multi.sv
// Multi-product vending controller: coin credit, per-product price and stock,
// a one-cycle vend pulse followed by an optional one-cycle change pulse.
module vending_machine_multi #(
  parameter int                          N_PROD     = 4,
  parameter int                          SEL_W      = 3,
  parameter int                          CREDIT_W   = 6,
  parameter logic [N_PROD*CREDIT_W-1:0]  PRICES     = {6'd10, 6'd7, 6'd5, 6'd3},
  parameter int                          STOCK_W    = 4,
  parameter int                          STOCK_INIT = 5,
  parameter int                          MAX_CREDIT = 63
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [2:0]          in,
  input  logic [SEL_W-1:0]    p,
  input  logic                cancel,
  output logic                out,
  output logic [SEL_W-1:0]    out_id,
  output logic [CREDIT_W-1:0] change,
  output logic                change_valid,
  output logic [CREDIT_W-1:0] credit,
  output logic                coin_reject,
  output logic                sold_out,
  output logic                busy
);

  typedef enum logic [1:0] {IDLE, COLLECT, VEND, CHANGE} state_t;

  localparam logic [CREDIT_W:0]  MAX_C  = (CREDIT_W+1)'(MAX_CREDIT);
  localparam logic [STOCK_W-1:0] S_INIT = STOCK_W'(STOCK_INIT);

  state_t              state, state_n;
  logic [CREDIT_W-1:0] residual, residual_n, credit_n, cred_upd;
  logic [STOCK_W-1:0]  stock [N_PROD];
  logic [N_PROD-1:0]   sel_mask, stock_dec;
  logic                sel_valid;
  logic [CREDIT_W-1:0] sel_price;
  logic [STOCK_W-1:0]  sel_stock;
  logic [CREDIT_W:0]   coin_val, sum;
  logic                coin_ok;
  logic                out_n, change_valid_n, coin_reject_n, sold_out_n;
  logic [SEL_W-1:0]    out_id_n;
  logic [CREDIT_W-1:0] change_n;

  always_comb begin
    coin_ok  = 1'b1;
    coin_val = '0;
    case (in)
      3'd1:    coin_val = (CREDIT_W+1)'(1);
      3'd2:    coin_val = (CREDIT_W+1)'(2);
      3'd3:    coin_val = (CREDIT_W+1)'(5);
      3'd4:    coin_val = (CREDIT_W+1)'(10);
      default: coin_ok  = 1'b0;
    endcase
    sum = {1'b0, credit} + coin_val;

    sel_valid = 1'b0;
    sel_price = '0;
    sel_stock = '0;
    for (int k = 0; k < N_PROD; k++) begin
      sel_mask[k] = (p == SEL_W'(k + 1));
      if (sel_mask[k]) begin
        sel_valid = 1'b1;
        sel_price = PRICES[k*CREDIT_W +: CREDIT_W];
        sel_stock = stock[k];
      end
    end
  end

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_n        = state;
    credit_n       = credit;
    residual_n     = residual;
    cred_upd       = credit;
    stock_dec      = '0;
    out_n          = 1'b0;
    out_id_n       = '0;
    change_n       = '0;
    change_valid_n = 1'b0;
    coin_reject_n  = 1'b0;
    sold_out_n     = 1'b0;
    case (state)
      IDLE, COLLECT: begin
        if (cancel && state == COLLECT) begin
          state_n        = CHANGE;
          change_n       = credit;
          change_valid_n = 1'b1;
          coin_reject_n  = (in != 3'd0);
        end else begin
          if (in != 3'd0) begin
            if (coin_ok && sum <= MAX_C) cred_upd = sum[CREDIT_W-1:0];
            else                         coin_reject_n = 1'b1;
          end
          credit_n = cred_upd;
          state_n  = (cred_upd != '0) ? COLLECT : IDLE;
          // The price is compared against the credit including this cycle's coin.
          if (sel_valid) begin
            if (sel_stock == '0) begin
              sold_out_n = 1'b1;
            end else if (cred_upd >= sel_price) begin
              state_n    = VEND;
              out_n      = 1'b1;
              out_id_n   = p;
              stock_dec  = sel_mask;
              residual_n = cred_upd - sel_price;
            end
          end
        end
      end
      VEND: begin
        coin_reject_n = (in != 3'd0);
        if (residual != '0) begin
          state_n        = CHANGE;
          change_n       = residual;
          change_valid_n = 1'b1;
        end else begin
          state_n  = IDLE;
          credit_n = '0;
        end
      end
      CHANGE: begin
        coin_reject_n = (in != 3'd0);
        state_n       = IDLE;
        credit_n      = '0;
      end
      default: state_n = IDLE;
    endcase
  end

  // NOTE: the stock array is reset along with the control state because a
  // reset must restore every product's count, not just the FSM.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      credit       <= '0;
      residual     <= '0;
      out          <= 1'b0;
      out_id       <= '0;
      change       <= '0;
      change_valid <= 1'b0;
      coin_reject  <= 1'b0;
      sold_out     <= 1'b0;
      busy         <= 1'b0;
      for (int k = 0; k < N_PROD; k++) stock[k] <= S_INIT;
    end else begin
      state        <= state_n;
      credit       <= credit_n;
      residual     <= residual_n;
      out          <= out_n;
      out_id       <= out_id_n;
      change       <= change_n;
      change_valid <= change_valid_n;
      coin_reject  <= coin_reject_n;
      sold_out     <= sold_out_n;
      busy         <= (state_n == VEND) || (state_n == CHANGE);
      for (int k = 0; k < N_PROD; k++)
        if (stock_dec[k] && stock[k] != '0) stock[k] <= stock[k] - 1'b1;
    end
  end

endmodule

// File: doc/vending_machine_multi.md
VENDING_MACHINE_MULTI -- requirements
Module: vending_machine_multi

Interface
REQ-001 SHALL have parameter N_PROD, default 4: number of products, 1..(2**SEL_W)-1.
REQ-002 SHALL have parameter SEL_W, default 3: width of the product select.
REQ-003 SHALL have parameter CREDIT_W, default 6: width of credit and change.
REQ-004 SHALL have parameter PRICES, default {6'd10,6'd7,6'd5,6'd3}: flattened N_PROD*CREDIT_W price table, product 1 in the LSBs.
REQ-005 SHALL have parameter STOCK_W, default 4, and parameter STOCK_INIT, default 5: per-product stock counter width and reload value.
REQ-006 SHALL have parameter MAX_CREDIT, default 63: highest credit the block accepts.
REQ-007 SHALL have one clock; reset is synchronous and active-low (name the clock and reset ports as the codebase does; the polarity and synchronicity here are fixed).
REQ-008 clk  input  1  rising-edge clock.
REQ-009 rst  input  1  synchronous reset, active-low.
REQ-010 in  input  3  coin code: 0=none, 1=1 unit, 2=2, 3=5, 4=10, 5..7=invalid.
REQ-011 p  input  SEL_W  product select: 0=none, k=product k (1..N_PROD).
REQ-012 cancel  input  1  refund request.
REQ-013 out  output  1  one-cycle vend pulse.
REQ-014 out_id  output  SEL_W  product vended; valid with out, else 0.
REQ-015 change  output  CREDIT_W  refund amount; valid with change_valid, else 0.
REQ-016 change_valid  output  1  one-cycle change pulse.
REQ-017 credit  output  CREDIT_W  current accumulated credit.
REQ-018 coin_reject  output  1  one-cycle pulse when a coin is refused.
REQ-019 sold_out  output  1  one-cycle pulse when an empty product is selected.
REQ-020 busy  output  1  high in VEND and CHANGE.

Function
REQ-021 SHALL implement states IDLE (credit=0), COLLECT (credit>0), VEND, CHANGE; all outputs registered.
REQ-022 In IDLE/COLLECT a valid coin SHALL add its value to credit if the sum is at most MAX_CREDIT; otherwise credit is unchanged and coin_reject pulses next cycle.
REQ-023 Coin codes 5..7, and any coin arriving in VEND or CHANGE, SHALL pulse coin_reject next cycle with credit unchanged.
REQ-024 Coin and selection in the same cycle: the coin SHALL be added first, and the price compared against the updated credit.
REQ-025 Selection p in 1..N_PROD in IDLE/COLLECT: stock=0 -> sold_out pulse next cycle and state held; credit >= price -> VEND; otherwise no action.
REQ-026 p > N_PROD SHALL be ignored.
REQ-027 VEND (one cycle) SHALL drive out=1 and out_id=p, decrement that product's stock, and set residual = credit - price.
REQ-028 From VEND the next state SHALL be CHANGE if residual > 0, else IDLE with credit=0.
REQ-029 CHANGE (one cycle) SHALL drive change=residual and change_valid=1, clear credit, and go to IDLE.
REQ-030 Latency: selection sampled at edge k -> out high in cycle k+1 -> change_valid high in cycle k+2.
REQ-031 cancel in COLLECT SHALL go to CHANGE with residual=credit; it takes priority over same-cycle selection, and a same-cycle coin is rejected.
REQ-032 cancel SHALL be ignored in IDLE, VEND and CHANGE.
REQ-033 Stock counters SHALL saturate at 0, and SHALL never wrap.

Reset
REQ-034 While rst=0 at a clock edge: state=IDLE, credit=0, and out, out_id, change, change_valid, coin_reject, sold_out, busy = 0.
REQ-035 Reset SHALL reload every stock counter to STOCK_INIT.
REQ-036 Reset mid-VEND/CHANGE SHALL abort the operation: no out, no change pulse afterward, pending residual discarded.

Verification (default parameters)
REQ-037 Coin code 3, then p=1 -> out=1 with out_id=1 next cycle, then change_valid=1 with change=2, then IDLE with credit=0.
REQ-038 Coin code 2, coin code 1, then p=1 -> out pulse, no change_valid, credit=0.
REQ-039 Coin code 4, then cancel=1 -> change_valid=1 with change=10, no out pulse.
REQ-040 Six code-4 coins (credit=60), then code 3 -> coin_reject pulse, credit stays 60; code 6 -> coin_reject pulse.
REQ-041 Buy product 1 five times with exact credit; on the sixth, credit 3 plus p=1 -> sold_out pulse, credit stays 3, no out.
REQ-042 Assert rst=0 during the VEND cycle -> next cycle all outputs 0, credit=0, product 1 stock=5.
